// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types, transfer-size codes and LSU sequencer states.
// Lane helpers used by the load/store controller.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    localparam logic [2:0] SZ_BYTE = 3'b000;
    localparam logic [2:0] SZ_HALF = 3'b001;
    localparam logic [2:0] SZ_WORD = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_RESP
    } lsu_state_t;

    // Illegal size codes and sub-word misalignment never reach the bus.
    function automatic logic is_bad_req(input logic [2:0] size, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        if (size > SZ_WORD)
            bad = 1'b1;
        else if (size == SZ_HALF && addr_lo[0])
            bad = 1'b1;
        else if (size == SZ_WORD && addr_lo != 2'b00)
            bad = 1'b1;
        return bad;
    endfunction

    // Store data is replicated across lanes so the slave can pick any byte lane.
    function automatic logic [31:0] lane_replicate(input logic [2:0] size, input logic [31:0] d);
        logic [31:0] r;
        case (size)
            SZ_BYTE: r = {4{d[7:0]}};
            SZ_HALF: r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_load_fmt.sv
// Load formatter: lane shift of hrdata by the byte offset, then sign/zero extension.
// Purely combinational; no latency, no backpressure.
module lsu_load_fmt
    import ahb_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  size,
    input  logic        sgn,
    input  logic [31:0] hrdata,
    output logic [31:0] data
);

    logic [31:0] shifted;

    assign shifted = hrdata >> {addr_lo, 3'b000};

    always_comb begin
        data = shifted;
        case (size)
            SZ_BYTE: data = {{24{sgn & shifted[7]}}, shifted[7:0]};
            SZ_HALF: data = {{16{sgn & shifted[15]}}, shifted[15:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/ahb_lsu_ctrl.sv
// Load/store sequencer: one core request -> one NONSEQ AHB-Lite transfer -> one response pulse.
// Latency: response 3 cycles after accept (+1 per hready-low cycle); 1 cycle for rejected requests.
// Backpressure: req_ready only in IDLE; bus stalls follow hready, at most one transfer outstanding.
module ahb_lsu_ctrl
    import ahb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [AW-1:0] req_addr,
    input  logic [2:0]    req_size,
    input  logic          req_signed,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic [AW-1:0] haddr,
    output logic [1:0]    htrans,
    output logic          hwrite,
    output logic [2:0]    hsize,
    output logic [DW-1:0] hwdata,
    input  logic [DW-1:0] hrdata,
    input  logic          hready,
    input  logic          hresp
);

    lsu_state_t    state, state_nxt;
    logic          accept;
    logic          bad_req;
    logic          data_done;
    logic          sgn_q;
    logic [DW-1:0] fmt_data;

    assign bad_req   = is_bad_req(req_size, req_addr[1:0]);
    assign data_done = (state == ST_DATA) && hready;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = bad_req ? ST_RESP : ST_ADDR;
                end
            end
            ST_ADDR: if (hready) state_nxt = ST_DATA;
            // A slave ERROR holds hready low for its first cycle, so waiting on hready covers it.
            ST_DATA: if (hready) state_nxt = ST_RESP;
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    lsu_load_fmt u_load_fmt (
        .addr_lo (haddr[1:0]),
        .size    (hsize),
        .sgn     (sgn_q),
        .hrdata  (hrdata),
        .data    (fmt_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
            htrans    <= HTRANS_IDLE;
            haddr     <= '0;
            hwrite    <= 1'b0;
            hsize     <= 3'b000;
            hwdata    <= '0;
            sgn_q     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            req_ready <= (state_nxt == ST_IDLE);
            htrans    <= (state_nxt == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
            rsp_valid <= (state_nxt == ST_RESP);

            // Bus-side latch doubles as request storage; hwdata is loaded early so it is stable all through DATA.
            if (accept && !bad_req) begin
                haddr  <= req_addr;
                hsize  <= req_size;
                hwrite <= req_write;
                sgn_q  <= req_signed;
                if (req_write)
                    hwdata <= lane_replicate(req_size, req_wdata);
            end

            if (accept && bad_req) begin
                rsp_err   <= 1'b1;
                rsp_rdata <= '0;
            end else if (data_done) begin
                rsp_err   <= hresp;
                rsp_rdata <= (hresp || hwrite) ? '0 : fmt_data;
            end
        end
    end

endmodule

// File: tb/tb_ahb_lsu_ctrl.sv
// Scoreboard bench for ahb_lsu_ctrl with a behavioural AHB slave and reference model.
module tb_ahb_lsu_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [2:0]  req_size;
    logic        req_signed;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;

    ahb_lsu_ctrl #(.AW(32), .DW(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .haddr      (haddr),
        .htrans     (htrans),
        .hwrite     (hwrite),
        .hsize      (hsize),
        .hwdata     (hwdata),
        .hrdata     (hrdata),
        .hready     (hready),
        .hresp      (hresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        err;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endfunction

    // Reference model, from the byte-lane arithmetic of the bus rather than bit slicing.
    function automatic logic [31:0] ref_load(input logic [31:0] addr, input int size, input bit sgn, input logic [31:0] word);
        logic [31:0] v;
        v = word >> (8 * (addr % 4));
        if (size == 0) begin
            v = v % 256;
            if (sgn && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (size == 1) begin
            v = v % 65536;
            if (sgn && v >= 32768) v = v + 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_store(input int size, input logic [31:0] d);
        if (size == 0) return (d % 256) * 32'h0101_0101;
        if (size == 1) return (d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    function automatic bit ref_bad(input logic [31:0] addr, input int size);
        if (size > 2) return 1'b1;
        return (addr % (1 << size)) != 0;
    endfunction

    // Monitor: every response pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp_valid", {31'd0, rsp_valid}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                chk("rsp_rdata", rsp_rdata, e.data);
                chk("rsp_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("req_ready_timeout", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("rsp_timeout", exp_q.size(), 32'd0);
            exp_q.delete();
        end
    endtask

    task automatic do_req(input bit wr, input logic [31:0] addr, input int size, input bit sgn,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input int aw, input int dw, input bit serr);
        exp_t e;
        bit   bad;
        int   t;
        int   dwn;
        dwn = (serr && dw == 0) ? 1 : dw;
        wait_ready();
        t = cyc;
        req_valid  = 1'b1;
        req_write  = wr;
        req_addr   = addr;
        req_size   = size[2:0];
        req_signed = sgn;
        req_wdata  = wdata;
        bad = ref_bad(addr, size);
        if (bad) begin
            e.err = 1'b1; e.data = 32'd0; e.cyc = t + 1;
        end else begin
            e.err  = serr;
            e.data = (serr || wr) ? 32'd0 : ref_load(addr, size, sgn, rdata);
            e.cyc  = t + 3 + aw + dwn;
        end
        exp_q.push_back(e);
        if (bad) begin
            @(negedge clk);
            req_valid = 1'b0;
            chk("no_nonseq_on_bad", {30'd0, htrans}, 32'd0);
        end else begin
            for (int i = 0; i <= aw; i++) begin
                @(negedge clk);
                req_valid = 1'b0;
                chk("addr_htrans", {30'd0, htrans}, 32'd2);
                chk("addr_haddr", haddr, addr);
                chk("addr_hwrite", {31'd0, hwrite}, {31'd0, wr});
                chk("addr_hsize", {29'd0, hsize}, size);
                chk("busy_req_ready", {31'd0, req_ready}, 32'd0);
                hready = (i == aw);
                hresp  = 1'b0;
            end
            for (int i = 0; i <= dwn; i++) begin
                @(negedge clk);
                chk("data_htrans", {30'd0, htrans}, 32'd0);
                if (wr) chk("data_hwdata", hwdata, ref_store(size, wdata));
                hready = (i == dwn);
                hresp  = serr && (i >= dwn - 1);
                hrdata = (i == dwn) ? rdata : $urandom;
            end
            @(negedge clk);
            hready = 1'b1;
            hresp  = 1'b0;
        end
        drain();
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_size = '0;
        req_signed = 1'b0; req_wdata = '0; hrdata = '0; hready = 1'b1; hresp = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_htrans", {30'd0, htrans}, 32'd0);
        chk("rst_haddr", haddr, 32'd0);
        chk("rst_hwdata", hwdata, 32'd0);
        chk("rst_hwrite_hsize", {28'd0, hwrite, hsize}, 32'd0);
        chk("rst_rsp", {rsp_rdata[30:0], rsp_valid} | {31'd0, rsp_err}, 32'd0);
        rst_n = 1'b1;

        // Directed cases
        do_req(1'b0, 32'h103, 0, 1'b1, 32'd0, 32'h80FF_1234, 0, 0, 1'b0);
        do_req(1'b0, 32'h202, 1, 1'b0, 32'd0, 32'h9ABC_0000, 0, 2, 1'b0);
        do_req(1'b1, 32'h301, 0, 1'b0, 32'h0000_00A5, 32'd0, 0, 0, 1'b0);
        do_req(1'b0, 32'h102, 2, 1'b0, 32'd0, 32'd0, 0, 0, 1'b0);
        do_req(1'b0, 32'h100, 3, 1'b0, 32'd0, 32'd0, 0, 0, 1'b0);
        do_req(1'b0, 32'h104, 2, 1'b0, 32'd0, 32'h1234_5678, 1, 1, 1'b1);
        wait_ready();
        chk("ready_after_err", {31'd0, req_ready}, 32'd1);

        // Reset in the middle of a stalled store data phase
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h500; req_size = 3'b010;
        req_signed = 1'b0; req_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        req_valid = 1'b0; hready = 1'b1;
        @(negedge clk);
        hready = 1'b0;
        chk("abort_hwdata_pre", hwdata, 32'hDEAD_BEEF);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_htrans", {30'd0, htrans}, 32'd0);
        chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("abort_hwdata", hwdata, 32'd0);
        chk("abort_haddr", haddr, 32'd0);
        chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        hready = 1'b1;
        rst_n = 1'b1;
        do_req(1'b0, 32'h400, 2, 1'b0, 32'd0, 32'hCAFE_F00D, 0, 0, 1'b0);

        // Randomized traffic
        for (int k = 0; k < 150; k++) begin
            int          sz;
            logic [31:0] a;
            sz = ($urandom_range(0, 9) == 0) ? $urandom_range(3, 7) : $urandom_range(0, 2);
            a  = $urandom;
            if ($urandom_range(0, 3) != 0 && sz <= 2) a = a & ~((32'd1 << sz) - 1);
            do_req($urandom_range(0, 1) == 1, a, sz, $urandom_range(0, 1) == 1, $urandom, $urandom,
                   $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 7) == 0);
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
